wb_cmd_master: RTL
==================

Name: wb_cmd_master

Overview:
- Wishbone initiator for the SoC's lightweight bus: wb_cyc/wb_we/wb_addr/wb_wdata out, wb_ack/wb_rdata in, no stb/sel.
- Accepts read or write commands on a valid/ready stream, runs single or auto-incrementing burst accesses, and returns one response per beat on a valid/ready stream.
- Drives peripheral register blocks from a host bridge (UART/SPI debug path).
- Includes an ack timeout so a missing responder cannot hang the bridge.

Parameters:
AW, 4, word-address width of wb_addr/cmd_addr
TIMEOUT, 255, cycles wb_cyc may stay high without wb_ack before abort (1..65535)
LENW, 8, width of cmd_len

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when valid&ready
cmd_we  in  1  1=write, 0=read
cmd_addr  in  AW  start word address
cmd_wdata  in  32  write data, same value for every beat
cmd_len  in  LENW  beats minus 1
cmd_inc  in  1  1=increment address each beat, 0=fixed address (FIFO/poll)
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when valid&ready
rsp_data  out  32  read data; 0 for writes and errors
rsp_err  out  1  beat timed out
rsp_last  out  1  final response of the command
wb_cyc  out  1  bus cycle active
wb_we  out  1  write strobe
wb_addr  out  AW  word address
wb_wdata  out  32  write data
wb_ack  in  1  responder acknowledge
wb_rdata  in  32  responder read data, valid when wb_ack
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async assert, sync deassert in integration):
  - State IDLE.
  - wb_cyc, wb_we, rsp_valid, rsp_err, rsp_last = 0.
  - wb_addr, wb_wdata, rsp_data = 0; beat and timeout counters = 0.
  - Reset mid-cycle drops wb_cyc immediately; no response is emitted.
- All outputs are registered. cmd_ready = (state==IDLE), combinational from state only.
- FSM states: IDLE, BUS, RSP.
- IDLE:
  - On cmd_valid&cmd_ready, latch we/addr/wdata/len/inc, load beats_left=cmd_len, clear timeout counter.
  - Set wb_cyc=1 and drive wb_we/wb_addr/wb_wdata. Go to BUS.
  - Latency: wb_cyc high the cycle after acceptance.
- BUS:
  - wb_cyc, wb_we, wb_addr, wb_wdata held stable.
  - wb_ack=1: wb_cyc<=0, wb_we<=0, rsp_valid<=1, rsp_data<=(we?0:wb_rdata), rsp_err<=0, rsp_last<=(beats_left==0). Go to RSP.
  - wb_cyc is low the cycle after the ack edge, so responders with a one-cycle ack pulse never see a second cycle.
  - Timeout counter increments each BUS cycle without ack. At TIMEOUT: wb_cyc<=0, rsp_valid<=1, rsp_data<=0, rsp_err<=1, rsp_last<=1, remaining beats discarded. Go to RSP.
  - wb_ack and timeout on the same cycle: ack wins, no error.
- RSP:
  - rsp_* held stable while rsp_valid&~rsp_ready.
  - On rsp_ready: rsp_valid<=0.
    - If rsp_last: go to IDLE.
    - Else: beats_left-=1, wb_addr+=cmd_inc (wraps modulo 2^AW), clear timeout counter, wb_cyc<=1. Go to BUS.
  - wb_cyc is therefore low for at least one cycle between beats.
- wb_ack seen in IDLE or RSP (late ack after a timeout) is ignored and does not corrupt rsp_data.
- Best case for a one-wait responder: accept at t0, wb_cyc t1, ack t2, rsp_valid t3.
- Throughput with rsp_ready tied high: one beat per 3 cycles.
- busy = (state!=IDLE).

Decomposition:
- Shared header/package holds: FSM state encoding (IDLE=2'd0, BUS=2'd1, RSP=2'd2) and the bus data width constant 32, reused by other initiators.
- One natural sub-module, wb_ack_timeout: clear/enable inputs, expired output, width $clog2(TIMEOUT+1).

Test Plan:
- Single read: cmd_we=0, addr=3, len=0. Responder acks 1 cycle after cyc with 0x00001234. Expect rsp_data=0x00001234, err=0, last=1, wb_cyc high exactly 2 cycles, rsp_valid 3 cycles after accept.
- Write burst: we=1, addr=0xE, len=2, inc=1, wdata=0xA5A5A5A5. Expect wb_addr sequence 0xE,0xF,0x0 (wrap); 3 responses with data=0 and last only on the third; wb_cyc low ≥1 cycle between beats.
- Backpressure: read burst len=1, rsp_ready held low 10 cycles. Expect rsp_valid/rsp_data stable, no second wb_cyc until the handshake, then the second beat issues.
- Timeout: TIMEOUT=8, responder never acks. Expect wb_cyc high 8 cycles then low; rsp_err=1, rsp_last=1, rsp_data=0; remaining burst beats dropped. A late ack 2 cycles later is ignored.
- Ack on timeout cycle: ack arrives exactly on cycle TIMEOUT. Expect err=0 and the read data returned.
- Async reset: assert rst_n=0 while wb_cyc=1 mid-burst. Expect wb_cyc=0 and rsp_valid=0 immediately, cmd_ready=1 after release, next command runs normally.

Source files
------------

// File: rtl/wb_cmd_master_pkg.sv
// Shared definitions for the lightweight Wishbone initiators: FSM encoding and bus data width.
package wb_cmd_master_pkg;

    localparam int WB_DW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RSP  = 2'd2
    } state_t;

endpackage

// File: rtl/wb_ack_timeout.sv
// Ack watchdog: counts enabled cycles since the last clear and flags the TIMEOUT-th one.
module wb_ack_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + CW'(1);
        end
    end

    // Fires during the TIMEOUT-th waiting cycle so wb_cyc drops after exactly TIMEOUT cycles.
    assign expired = enable && (count_reg == CW'(TIMEOUT - 1));

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone command initiator: single/burst accesses from a cmd stream, one response per beat.
module wb_cmd_master
    import wb_cmd_master_pkg::*;
#(
    parameter int AW      = 4,
    parameter int TIMEOUT = 255,
    parameter int LENW    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [AW-1:0]    cmd_addr,
    input  logic [WB_DW-1:0] cmd_wdata,
    input  logic [LENW-1:0]  cmd_len,
    input  logic             cmd_inc,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WB_DW-1:0] rsp_data,
    output logic             rsp_err,
    output logic             rsp_last,
    output logic             wb_cyc,
    output logic             wb_we,
    output logic [AW-1:0]    wb_addr,
    output logic [WB_DW-1:0] wb_wdata,
    input  logic             wb_ack,
    input  logic [WB_DW-1:0] wb_rdata,
    output logic             busy
);

    state_t             state_reg, state_next;
    logic [LENW-1:0]    beats_left_reg, beats_left_next;
    logic               we_reg, we_next;
    logic               inc_reg, inc_next;
    logic               wb_cyc_reg, wb_cyc_next;
    logic               wb_we_reg, wb_we_next;
    logic [AW-1:0]      wb_addr_reg, wb_addr_next;
    logic [WB_DW-1:0]   wb_wdata_reg, wb_wdata_next;
    logic               rsp_valid_reg, rsp_valid_next;
    logic [WB_DW-1:0]   rsp_data_reg, rsp_data_next;
    logic               rsp_err_reg, rsp_err_next;
    logic               rsp_last_reg, rsp_last_next;
    logic               to_expired;

    wb_ack_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_reg != BUS),
        .enable  ((state_reg == BUS) && !wb_ack),
        .expired (to_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            beats_left_reg <= '0;
            we_reg         <= 1'b0;
            inc_reg        <= 1'b0;
            wb_cyc_reg     <= 1'b0;
            wb_we_reg      <= 1'b0;
            wb_addr_reg    <= '0;
            wb_wdata_reg   <= '0;
            rsp_valid_reg  <= 1'b0;
            rsp_data_reg   <= '0;
            rsp_err_reg    <= 1'b0;
            rsp_last_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            beats_left_reg <= beats_left_next;
            we_reg         <= we_next;
            inc_reg        <= inc_next;
            wb_cyc_reg     <= wb_cyc_next;
            wb_we_reg      <= wb_we_next;
            wb_addr_reg    <= wb_addr_next;
            wb_wdata_reg   <= wb_wdata_next;
            rsp_valid_reg  <= rsp_valid_next;
            rsp_data_reg   <= rsp_data_next;
            rsp_err_reg    <= rsp_err_next;
            rsp_last_reg   <= rsp_last_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        beats_left_next = beats_left_reg;
        we_next         = we_reg;
        inc_next        = inc_reg;
        wb_cyc_next     = wb_cyc_reg;
        wb_we_next      = wb_we_reg;
        wb_addr_next    = wb_addr_reg;
        wb_wdata_next   = wb_wdata_reg;
        rsp_valid_next  = rsp_valid_reg;
        rsp_data_next   = rsp_data_reg;
        rsp_err_next    = rsp_err_reg;
        rsp_last_next   = rsp_last_reg;
        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    we_next         = cmd_we;
                    inc_next        = cmd_inc;
                    beats_left_next = cmd_len;
                    wb_cyc_next     = 1'b1;
                    wb_we_next      = cmd_we;
                    wb_addr_next    = cmd_addr;
                    wb_wdata_next   = cmd_wdata;
                    state_next      = BUS;
                end
            end
            BUS: begin
                // Ack has priority over an expiry landing on the same cycle.
                if (wb_ack) begin
                    wb_cyc_next    = 1'b0;
                    wb_we_next     = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_data_next  = we_reg ? '0 : wb_rdata;
                    rsp_err_next   = 1'b0;
                    rsp_last_next  = (beats_left_reg == '0);
                    state_next     = RSP;
                end else if (to_expired) begin
                    wb_cyc_next    = 1'b0;
                    wb_we_next     = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_data_next  = '0;
                    rsp_err_next   = 1'b1;
                    rsp_last_next  = 1'b1;
                    state_next     = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    if (rsp_last_reg) begin
                        state_next = IDLE;
                    end else begin
                        beats_left_next = beats_left_reg - LENW'(1);
                        wb_addr_next    = wb_addr_reg + AW'(inc_reg);
                        wb_cyc_next     = 1'b1;
                        wb_we_next      = we_reg;
                        state_next      = BUS;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign cmd_ready = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign wb_cyc    = wb_cyc_reg;
    assign wb_we     = wb_we_reg;
    assign wb_addr   = wb_addr_reg;
    assign wb_wdata  = wb_wdata_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_err   = rsp_err_reg;
    assign rsp_last  = rsp_last_reg;

endmodule
